mem_req_ctrl: RTL
=================

# mem_req_ctrl

Request-side controller for `mem_unit`. It accepts byte-addressed load/store requests from the pipeline over a valid/ready handshake and drives the `mem_unit` port (`en`/`wr`/`addr`/`data`). It performs byte/halfword/word accesses, using read-modify-write for sub-word stores. Read data returns sign- or zero-extended on a valid/ready response channel.

## Interface
- `ADDR_W`, default 11: `mem_unit` word-address width. Byte address is `ADDR_W+2` bits.
- `DATA_W`, default 32: word width. Only 32 is supported.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  controller can accept a request (IDLE only).
- `req_wr_i`  in  1  1 = store, 0 = load.
- `req_size_i`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_signed_i`  in  1  sign-extend load result.
- `req_addr_i`  in  ADDR_W+2  byte address.
- `req_data_i`  in  32  store data, right-aligned.
- `rsp_valid_o`  out  1  response present.
- `rsp_ready_i`  in  1  consumer takes response.
- `rsp_data_o`  out  32  load result; 0 for stores and errors.
- `rsp_err_o`  out  1  misaligned or illegal-size request.
- `mem_en_o`, `mem_wr_o`  out  1 each  to `mem_unit` `en_i`/`wr_i`.
- `mem_addr_o`  out  ADDR_W  word address = byte address >> 2.
- `mem_data_o`  out  32  write data to `mem_unit`.
- `mem_data_i`  in  32  `mem_unit` `data_o`.

## Operation
- Handshake:
  - A request is accepted on an edge with `req_valid_i && req_ready_o`.
  - All request fields are registered at that edge; inputs are don't-care afterwards.
  - Exactly one outstanding request.
- Byte lanes are little-endian.
  - Byte lane is `addr[1:0]`; halfword lane is `addr[1]`.
  - A byte at `addr[1:0]=k` occupies bits `[8k+7:8k]`.
- `mem_unit` read is synchronous. `mem_data_i` is valid in the cycle after a cycle with `mem_en_o=1, mem_wr_o=0`.
- FSM states: IDLE, RD_ISSUE, RD_CAP, WRITE, RESP.
  - IDLE, on accept:
    - Error: half with `addr[0]=1`, word with `addr[1:0]!=0`, or size 11 → RESP with err=1. No memory access is made.
    - Word store → WRITE.
    - Any load or sub-word store → RD_ISSUE.
  - RD_ISSUE: drive `mem_en_o=1, mem_wr_o=0` → RD_CAP.
  - RD_CAP:
    - Load: extract the lane, extend it, register it into `rsp_data_o` → RESP.
    - Sub-word store: merge store bytes into `mem_data_i`, register the result into `mem_data_o` → WRITE.
  - WRITE: drive `mem_en_o=1, mem_wr_o=1` → RESP.
  - RESP: `rsp_valid_o=1`, held with stable data/err until `rsp_ready_i` → IDLE.
- Extension:
  - Signed byte/half replicates the top bit of the lane; unsigned zero-fills.
  - `req_signed_i` is ignored for words and stores.
- `mem_en_o`/`mem_wr_o` are 0 in IDLE, RD_CAP (`mem_wr_o`) and RESP. `mem_addr_o`/`mem_data_o` are registered and hold their last value.

## Timing
- Reset values: `req_ready_o=0`; every other output 0. The first cycle after reset release enters IDLE, with `req_ready_o=1` combinational from state.
- Latency from the accept edge to `rsp_valid_o` high:
  - word store: 2 cycles;
  - load: 3 cycles;
  - sub-word store: 4 cycles;
  - error: 1 cycle.
- Minimum request-to-request spacing is latency + 1 (the RESP handshake cycle).
- `rsp_ready_i` already high on entry to RESP: one cycle in RESP, then IDLE.
- `rsp_ready_i` low: remain in RESP indefinitely; `req_ready_o=0`.
- Reset asserted mid-operation:
  - Immediate return to the reset state; `mem_en_o`/`mem_wr_o` drop asynchronously.
  - A WRITE not yet sampled by a clock edge is lost.
  - A pending response is discarded.
- Maximum address wraps naturally; there is no special case.

## Structure
- Shared `mem_pkg` holds:
  - the size encodings (`SZ_B`, `SZ_H`, `SZ_W`);
  - the FSM state enum;
  - the default `ADDR_W`/`DATA_W` constants, reused by `mem_unit`.
- One combinational sub-module, `mem_lane_merge`:
  - load path: extract/extend, inputs (word, lane, size, signed);
  - store path: merge, inputs (old word, new data, lane, size).
- The FSM and registers stay in `mem_req_ctrl`.

## Test plan
The bench instantiates `mem_req_ctrl` wired to a real `mem_unit`.
- Word store `0xDEADBEEF` at byte `0x00C` → WRITE with `mem_addr_o=3`. Word load at `0x00C` returns `0xDEADBEEF`, err=0, 3-cycle latency.
- Signed byte load at `0x00D` → `0xFFFFFFBE`. Unsigned → `0x000000BE`. Unsigned half at `0x00E` → `0x0000DEAD`.
- Half store `0x1234` at `0x00E`: RD_ISSUE, RD_CAP, WRITE sequence observed on the `mem_*` pins. The following word load returns `0x1234BEEF`.
- Word load at `0x006`, and any request with size 11 → `rsp_err_o=1`, data 0, `mem_en_o` never asserted, 1-cycle latency.
- Load with `rsp_ready_i` held low for 5 cycles → `rsp_valid_o` and data stable throughout, `req_ready_o=0`, then IDLE one cycle after ready rises.
- Byte store `0xAA` at `0x010` with `rst_n_i` pulsed low during WRITE, before the edge → all outputs 0 immediately. The following word load at `0x010` returns the pre-store value.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory request controller and mem_unit.
package mem_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_ILL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_CAP,
    ST_WRITE,
    ST_RESP
  } state_t;

  // A request is rejected for an illegal size or a lane that breaks natural alignment.
  function automatic logic req_bad(input logic [1:0] size, input logic [1:0] lane);
    return (size == SZ_ILL) || (size == SZ_H && lane[0]) || (size == SZ_W && lane != 2'b00);
  endfunction

endpackage

// File: rtl/mem_req_ctrl_if.sv
// Request/response handshake plus mem_unit port, as seen by the controller.
interface mem_req_ctrl_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_wr_i;
  logic [1:0]        req_size_i;
  logic              req_signed_i;
  logic [ADDR_W+1:0] req_addr_i;
  logic [DATA_W-1:0] req_data_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_data_o;
  logic              rsp_err_o;
  logic              mem_en_o;
  logic              mem_wr_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [DATA_W-1:0] mem_data_i;

  modport slave (
    input  req_valid_i, req_wr_i, req_size_i, req_signed_i, req_addr_i, req_data_i,
    input  rsp_ready_i, mem_data_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
    output mem_en_o, mem_wr_o, mem_addr_o, mem_data_o
  );

  modport master (
    output req_valid_i, req_wr_i, req_size_i, req_signed_i, req_addr_i, req_data_i,
    output rsp_ready_i, mem_data_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
    input  mem_en_o, mem_wr_o, mem_addr_o, mem_data_o
  );

endinterface

// File: rtl/mem_lane_merge.sv
// Little-endian lane handling: load extract/extend and sub-word store merge.
module mem_lane_merge
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  function automatic logic [31:0] ext_byte(input logic signed [7:0] b, input logic sgn);
    return sgn ? 32'(b) : {24'd0, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic signed [15:0] h, input logic sgn);
    return sgn ? 32'(h) : {16'd0, h};
  endfunction

  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;

  // Load path: pick the addressed lane and extend it to a full word.
  always_comb begin
    lane_b    = word[{lane, 3'b000} +: 8];
    lane_h    = lane[1] ? word[31:16] : word[15:0];
    load_data = word;
    case (size)
      SZ_B:    load_data = ext_byte(lane_b, sign_ext);
      SZ_H:    load_data = ext_half(lane_h, sign_ext);
      default: load_data = word;
    endcase
  end

  // Store path: overwrite only the addressed lane of the word read back.
  always_comb begin
    merged = old_word;
    case (size)
      SZ_B: merged[{lane, 3'b000} +: 8] = new_data[7:0];
      SZ_H: begin
        if (lane[1]) merged[31:16] = new_data[15:0];
        else         merged[15:0]  = new_data[15:0];
      end
      default: merged = new_data;
    endcase
  end

endmodule

// File: rtl/mem_unit.sv
// Single-port word memory with synchronous read.
module mem_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Write when enabled for write, otherwise register the addressed word.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (wr_i) mem[addr_i] <= data_i;
      else      data_o      <= mem[addr_i];
    end
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Request-side controller: byte/half/word loads and stores onto mem_unit,
// sub-word stores done as read-modify-write.
module mem_req_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  mem_req_ctrl_if.slave  bus
);

  state_t            state;
  logic              out_of_reset;
  logic              accept;
  logic              bad;
  logic              wr_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [1:0]        lane_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged;
  logic [ADDR_W-1:0] word_addr;

  assign bus.req_ready_o = out_of_reset && (state == ST_IDLE);
  assign accept          = bus.req_valid_i && bus.req_ready_o;
  assign bad             = req_bad(bus.req_size_i, bus.req_addr_i[1:0]);
  assign word_addr       = bus.req_addr_i[ADDR_W+1:2];

  // Request fields are captured at the accept edge; later input changes are ignored.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      wr_q     <= bus.req_wr_i;
      size_q   <= bus.req_size_i;
      signed_q <= bus.req_signed_i;
      lane_q   <= bus.req_addr_i[1:0];
      data_q   <= bus.req_data_i;
    end
  end

  mem_lane_merge u_lane (
    .word      (bus.mem_data_i),
    .old_word  (bus.mem_data_i),
    .new_data  (data_q),
    .lane      (lane_q),
    .size      (size_q),
    .sign_ext  (signed_q),
    .load_data (load_data),
    .merged    (merged)
  );

  // Control FSM; every output is registered so reset clears them all at once.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state           <= ST_IDLE;
      out_of_reset    <= 1'b0;
      bus.mem_en_o    <= 1'b0;
      bus.mem_wr_o    <= 1'b0;
      bus.mem_addr_o  <= '0;
      bus.mem_data_o  <= '0;
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_data_o  <= '0;
      bus.rsp_err_o   <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            bus.rsp_data_o <= '0;
            if (bad) begin
              bus.rsp_err_o   <= 1'b1;
              bus.rsp_valid_o <= 1'b1;
              state           <= ST_RESP;
            end else begin
              bus.rsp_err_o  <= 1'b0;
              bus.mem_addr_o <= word_addr;
              bus.mem_en_o   <= 1'b1;
              if (bus.req_wr_i && bus.req_size_i == SZ_W) begin
                bus.mem_wr_o   <= 1'b1;
                bus.mem_data_o <= bus.req_data_i;
                state          <= ST_WRITE;
              end else begin
                bus.mem_wr_o <= 1'b0;
                state        <= ST_RD_ISSUE;
              end
            end
          end
        end
        ST_RD_ISSUE: begin
          bus.mem_en_o <= 1'b0;
          state        <= ST_RD_CAP;
        end
        ST_RD_CAP: begin
          if (wr_q) begin
            bus.mem_data_o <= merged;
            bus.mem_en_o   <= 1'b1;
            bus.mem_wr_o   <= 1'b1;
            state          <= ST_WRITE;
          end else begin
            bus.rsp_data_o  <= load_data;
            bus.rsp_valid_o <= 1'b1;
            state           <= ST_RESP;
          end
        end
        ST_WRITE: begin
          bus.mem_en_o    <= 1'b0;
          bus.mem_wr_o    <= 1'b0;
          bus.rsp_valid_o <= 1'b1;
          state           <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready_i) begin
            bus.rsp_valid_o <= 1'b0;
            state           <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
